// File: rtl/res_display.sv
// Latches an 8-bit result on load, converts it to 3-digit BCD by sequential double-dabble,
// and scans it onto a 3-digit common-anode 7-segment display. Optional: RES_DISPLAY_LZB_EN.
module res_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  res,
  input  logic        load,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [7:0]      sh;
  logic [11:0]     acc;
  logic [11:0]     acc_adj;
  logic [2:0]      bit_cnt;
  logic [CW-1:0]   scan_cnt;
  logic [1:0]      idx;
  logic [3:0]      nib;
  logic            blank;
  logic [6:0]      seg_nxt;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_pat(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    acc_adj = {adj3(acc[11:8]), adj3(acc[7:4]), adj3(acc[3:0])};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sh      <= '0;
      acc     <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          sh      <= res;
          acc     <= '0;
          bit_cnt <= 3'd7;
          busy    <= 1'b1;
          state   <= SHIFT;
        end
        SHIFT: begin
          // adjust-then-shift: one result bit enters the accumulator per cycle
          acc <= {acc_adj[10:0], sh[7]};
          sh  <= {sh[6:0], 1'b0};
          if (bit_cnt == 3'd0) state <= DONE;
          else                 bit_cnt <= bit_cnt - 3'd1;
        end
        DONE: begin
          bcd   <= acc;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    nib   = 4'd0;
    blank = 1'b0;
    case (idx)
      2'd0: nib = bcd[3:0];
      2'd1: nib = bcd[7:4];
      2'd2: nib = bcd[11:8];
      default: nib = 4'hF;
    endcase
`ifdef RES_DISPLAY_LZB_EN
    if (idx == 2'd2 && bcd[11:8] == 4'd0)                      blank = 1'b1;
    if (idx == 2'd1 && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) blank = 1'b1;
`endif
    seg_nxt = blank ? 7'h7F : seg_pat(nib);
  end

  // the digit at idx is latched at the wrap, then idx moves on to the next digit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      seg      <= 7'h7F;
      an       <= 3'b111;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      seg      <= seg_nxt;
      an       <= ~(3'b001 << idx);
      idx      <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_res_display.sv
// Scoreboard bench for res_display: loads push expected bcd, a monitor pops on each busy fall.
module tb_res_display;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  res = '0;
  logic        load = 1'b0;
  logic        busy;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  an;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];
  int run = 0;

  res_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .res(res), .load(load),
    .busy(busy), .bcd(bcd), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: counts busy-high cycles and checks bcd when a conversion completes
  always @(negedge clk) begin
    if (!reset) run = 0;
    else if (busy) run++;
    else if (run > 0) begin
      chk("busy_len", run, 9);
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("bcd", {20'd0, bcd}, {20'd0, exp_q.pop_front()});
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [7:0] v, input logic [11:0] e);
    res = v; load = 1'b1; exp_q.push_back(e);
    tick();
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (!busy && exp_q.size() == 0) break;
    end
    if (k == 40) chk("idle_timeout", 1, 0);
  endtask

  // expects a fresh an=110 refresh, then 4 cycles each of ones, tens, hundreds
  task automatic check_scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
    logic [6:0] es[3];
    logic [2:0] ea[3];
    int k;
    es[0] = s0; es[1] = s1; es[2] = s2;
    ea[0] = 3'b110; ea[1] = 3'b101; ea[2] = 3'b011;
    for (k = 0; k < 40; k++) begin @(negedge clk); if (an != 3'b110) break; end
    for (k = 0; k < 40; k++) begin @(negedge clk); if (an == 3'b110) break; end
    if (k == 40) begin chk("scan_timeout", 1, 0); return; end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      chk("scan_an", {29'd0, an}, {29'd0, ea[i/4]});
      chk("scan_seg", {25'd0, seg}, {25'd0, es[i/4]});
    end
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_bcd", {20'd0, bcd}, 0);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_an", {29'd0, an}, 32'h7);
    reset = 1'b1;
    tick();
    chk("post_rst_seg", {25'd0, seg}, 32'h7F);
    chk("post_rst_an", {29'd0, an}, 32'h7);

    // 1: 255
    do_load(8'd255, 12'h255);
    wait_idle();
    check_scan(7'h12, 7'h12, 7'h24);

    // 2: zero, with or without leading-zero blanking
    do_load(8'd0, 12'h000);
    wait_idle();
`ifdef RES_DISPLAY_LZB_EN
    check_scan(7'h40, 7'h7F, 7'h7F);
`else
    check_scan(7'h40, 7'h40, 7'h40);
`endif

    // 3: load during busy is ignored
    do_load(8'd9, 12'h009);
    tick(); tick();
    res = 8'd200; load = 1'b1; tick(); load = 1'b0; res = 8'd77;
    wait_idle();
    chk("ignored_load_bcd", {20'd0, bcd}, 32'h009);
    do_load(8'd200, 12'h200);
    wait_idle();

    // 4: reset mid-conversion
    do_load(8'd137, 12'h137);
    tick(); tick(); tick();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_bcd", {20'd0, bcd}, 0);
    chk("abort_seg", {25'd0, seg}, 32'h7F);
    chk("abort_an", {29'd0, an}, 32'h7);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("after_abort_bcd", {20'd0, bcd}, 0);
    do_load(8'd137, 12'h137);
    wait_idle();

    // 5: load held high -> back-to-back conversions at E0, E10, E20
    res = 8'd58; load = 1'b1;
    exp_q.push_back(12'h058); exp_q.push_back(12'h058); exp_q.push_back(12'h058);
    repeat (21) tick();
    load = 1'b0;
    wait_idle();
    chk("held_bcd", {20'd0, bcd}, 32'h058);

    // 6: scan order
    do_load(8'd123, 12'h123);
    wait_idle();
    check_scan(7'h30, 7'h24, 7'h79);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
